// File: rtl/dense_result_collector_pkg.sv
// Shared types for the dense-dense multiplier result path: default sizes,
// collector state encoding and the element-pair record.
package dense_pkg;
  localparam int DEF_N  = 560;
  localparam int DEF_DW = 64;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_t;

  typedef struct packed {
    logic [DEF_DW-1:0] data0;
    logic [DEF_DW-1:0] data1;
  } pair_t;
endpackage

// File: rtl/dense_result_collector_if.sv
// Result-stream bundle between multiplier, collector and consumer.
// Optional row_sum signal is present when RESULT_ROWSUM_EN is defined.
interface dense_result_collector_if
  import dense_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int DW = DEF_DW
);
    localparam int RW = $clog2(N);

    logic          in_valid;
    logic [DW-1:0] in_data0;
    logic [DW-1:0] in_data1;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data0;
    logic [DW-1:0] out_data1;
    logic [RW-1:0] out_row;
    logic [RW-1:0] out_col;
    logic          row_done;
    logic          mat_done;
    logic          overflow;
`ifdef RESULT_ROWSUM_EN
    logic [DW+RW-1:0] row_sum;
`endif

    // Handshake: a pair transfers on a rising edge where out_valid and
    // out_ready are both 1; while out_valid=1 the head (data, row, col) is
    // held stable and out_valid only falls after a transfer. in_valid has
    // no ready: the producer never stalls.
    modport slave (
        input  in_valid, in_data0, in_data1, out_ready,
        output out_valid, out_data0, out_data1, out_row, out_col,
        output row_done, mat_done,
`ifdef RESULT_ROWSUM_EN
        output overflow, output row_sum
`else
        output overflow
`endif
    );

    modport master (
        output in_valid, in_data0, in_data1, out_ready,
        input  out_valid, out_data0, out_data1, out_row, out_col,
        input  row_done, mat_done,
`ifdef RESULT_ROWSUM_EN
        input  overflow, input row_sum
`else
        input  overflow
`endif
    );
endinterface

// File: rtl/dense_result_collector_sync_fifo.sv
// Single-clock FIFO with wrap-around pointers and an occupancy count.
// Head is read straight from storage so a pushed entry is visible after one edge.
module sync_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop frees the slot the full-case push writes into (wr_ptr == rd_ptr).
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/dense_result_collector.sv
// Buffers the multiplier's two-element result stream, tags each pair with its
// matrix position and hands it to a consumer. Optional row sum: RESULT_ROWSUM_EN.
module dense_result_collector
  import dense_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int DW    = DEF_DW,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    dense_result_collector_if.slave bus,
    output state_t                  dbg_state,
    output logic [$clog2(DEPTH):0]  dbg_count
);
    localparam int            RW       = $clog2(N);
    localparam logic [RW-1:0] LAST_COL = RW'(N - 2);
    localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

    state_t          state_q;
    state_t          state_d;
    logic [RW-1:0]   row_q;
    logic [RW-1:0]   col_q;
    logic            row_done_q;
    logic            mat_done_q;
    logic            overflow_q;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            last_col;
    logic            last_row;
    logic [2*DW-1:0] head;

    assign pop      = ~fifo_empty & bus.out_ready;
    assign push     = (state_q == RUN) & bus.in_valid & (~fifo_full | pop);
    assign last_col = (col_q == LAST_COL);
    assign last_row = (row_q == LAST_ROW);

    sync_fifo #(
        .WIDTH (2*DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({bus.in_data0, bus.in_data1}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (dbg_count)
    );

    always_comb begin
        state_d = state_q;
        if (state_q == RUN && pop && last_col && last_row) state_d = DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // Position advances in pop order, so it always names the current head.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q      <= '0;
            col_q      <= '0;
            row_done_q <= 1'b0;
            mat_done_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            row_done_q <= 1'b0;
            if (pop) begin
                if (last_col) begin
                    col_q      <= '0;
                    row_done_q <= 1'b1;
                    row_q      <= last_row ? '0 : row_q + RW'(1);
                    if (last_row) mat_done_q <= 1'b1;
                end else begin
                    col_q <= col_q + RW'(2);
                end
            end
            if (bus.in_valid && !push) overflow_q <= 1'b1;
        end
    end

`ifdef RESULT_ROWSUM_EN
    localparam int SW = DW + RW;

    logic [SW-1:0] sum_q;
    logic [SW-1:0] sum_base;

    // The finished row total is shown during the row_done cycle; a pop in that
    // same cycle already starts the next row from zero.
    assign sum_base = row_done_q ? '0 : sum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else if (pop) begin
            sum_q <= sum_base + SW'(head[2*DW-1:DW]) + SW'(head[DW-1:0]);
        end else if (row_done_q) begin
            sum_q <= '0;
        end
    end

    assign bus.row_sum = sum_q;
`endif

    assign bus.out_valid = ~fifo_empty;
    assign bus.out_data0 = head[2*DW-1:DW];
    assign bus.out_data1 = head[DW-1:0];
    assign bus.out_row   = row_q;
    assign bus.out_col   = col_q;
    assign bus.row_done  = row_done_q;
    assign bus.mat_done  = mat_done_q;
    assign bus.overflow  = overflow_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_dense_result_collector.sv
// Bench for dense_result_collector at N=4, DEPTH=4: vector table for the
// in-order matrix, scoreboard-driven sequences for stalls, overflow and reset.
module tb_dense_result_collector;
  import dense_pkg::*;

  localparam int N     = 4;
  localparam int DW    = 64;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  state_t     dbg_state;
  logic [2:0] dbg_count;

  dense_result_collector_if #(.N(N), .DW(DW)) bus ();

  dense_result_collector #(.N(N), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_count (dbg_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // scoreboard: {data0, data1} in expected pop order
  logic [2*DW-1:0] exp_q[$];
  int              m_pos;
  logic            m_ovf;
  logic            m_done;

  typedef struct {
    logic        iv;
    logic [63:0] d0;
    logic [63:0] d1;
    logic        rdy;
    logic        e_valid;
    logic [1:0]  e_row;
    logic [1:0]  e_col;
    logic [63:0] e_d0;
    logic [63:0] e_d1;
    logic        e_rd;
    logic        e_md;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data0  = '0;
    bus.in_data1  = '0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    m_pos  = 0;
    m_ovf  = 1'b0;
    m_done = 1'b0;
  endtask

  // One cycle: check the head against the scoreboard, drive, step, check flags.
  task automatic sb_cycle(input logic iv, input logic [63:0] d0, input logic [63:0] d1, input logic rdy);
    logic pop_now;
    logic push_ok;
    logic rd_exp;
    logic [2*DW-1:0] e;
    bus.in_valid  = iv;
    bus.in_data0  = d0;
    bus.in_data1  = d1;
    bus.out_ready = rdy;
    check("sb_out_valid", bus.out_valid, exp_q.size() > 0);
    pop_now = (exp_q.size() > 0) && rdy;
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      check("sb_data0", bus.out_data0, e[2*DW-1:DW]);
      check("sb_data1", bus.out_data1, e[DW-1:0]);
      check("sb_row", bus.out_row, m_pos / (N/2));
      check("sb_col", bus.out_col, 2 * (m_pos % (N/2)));
    end
    push_ok = iv && !m_done && ((exp_q.size() < DEPTH) || pop_now);
    if (iv && !push_ok) m_ovf = 1'b1;
    rd_exp = 1'b0;
    if (pop_now) begin
      void'(exp_q.pop_front());
      if ((m_pos % (N/2)) == (N/2 - 1)) rd_exp = 1'b1;
      if (m_pos == (N*N/2 - 1)) m_done = 1'b1;
      m_pos++;
    end
    if (push_ok) exp_q.push_back({d0, d1});
    @(posedge clk); #1;
    check("sb_row_done", bus.row_done, rd_exp);
    check("sb_mat_done", bus.mat_done, m_done);
    check("sb_overflow", bus.overflow, m_ovf);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) sb_cycle(1'b0, 64'd0, 64'd0, 1'b1);
    check("drain_empty", exp_q.size(), 0);
    check("drain_out_valid", bus.out_valid, 1'b0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_data0"}, bus.out_data0, 64'd0);
    check({tag, "_data1"}, bus.out_data1, 64'd0);
    check({tag, "_row"}, bus.out_row, 2'd0);
    check({tag, "_col"}, bus.out_col, 2'd0);
    check({tag, "_row_done"}, bus.row_done, 1'b0);
    check({tag, "_mat_done"}, bus.mat_done, 1'b0);
    check({tag, "_overflow"}, bus.overflow, 1'b0);
    check({tag, "_count"}, dbg_count, 3'd0);
    check({tag, "_state"}, dbg_state, RUN);
  endtask

  // Assumes a freshly reset DUT; leaves it in DONE.
  task automatic run_table();
    for (int i = 0; i < 9; i++) begin
      bus.in_valid  = vecs[i].iv;
      bus.in_data0  = vecs[i].d0;
      bus.in_data1  = vecs[i].d1;
      bus.out_ready = vecs[i].rdy;
      @(posedge clk); #1;
      check($sformatf("tbl%0d_valid", i), bus.out_valid, vecs[i].e_valid);
      check($sformatf("tbl%0d_data0", i), bus.out_data0, vecs[i].e_d0);
      check($sformatf("tbl%0d_data1", i), bus.out_data1, vecs[i].e_d1);
      if (vecs[i].e_valid) begin
        check($sformatf("tbl%0d_row", i), bus.out_row, vecs[i].e_row);
        check($sformatf("tbl%0d_col", i), bus.out_col, vecs[i].e_col);
      end
      check($sformatf("tbl%0d_row_done", i), bus.row_done, vecs[i].e_rd);
      check($sformatf("tbl%0d_mat_done", i), bus.mat_done, vecs[i].e_md);
      check($sformatf("tbl%0d_overflow", i), bus.overflow, 1'b0);
    end
    check("tbl_state_done", dbg_state, DONE);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int accepted;
    //           iv    d0      d1       rdy   vld   row   col   e_d0    e_d1     rd    md
    vecs[0] = '{1'b1, 64'd0, 64'd100, 1'b1, 1'b1, 2'd0, 2'd0, 64'd0, 64'd100, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 64'd1, 64'd101, 1'b1, 1'b1, 2'd0, 2'd2, 64'd1, 64'd101, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 64'd2, 64'd102, 1'b1, 1'b1, 2'd1, 2'd0, 64'd2, 64'd102, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 64'd3, 64'd103, 1'b1, 1'b1, 2'd1, 2'd2, 64'd3, 64'd103, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 64'd4, 64'd104, 1'b1, 1'b1, 2'd2, 2'd0, 64'd4, 64'd104, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 64'd5, 64'd105, 1'b1, 1'b1, 2'd2, 2'd2, 64'd5, 64'd105, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 64'd6, 64'd106, 1'b1, 1'b1, 2'd3, 2'd0, 64'd6, 64'd106, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 64'd7, 64'd107, 1'b1, 1'b1, 2'd3, 2'd2, 64'd7, 64'd107, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 64'd0, 64'd0,   1'b1, 1'b0, 2'd0, 2'd0, 64'd0, 64'd0,   1'b1, 1'b1};

    do_reset();
    check_cleared("reset");

    // full matrix streamed in order
    run_table();

    // input after the matrix is complete is lost
    bus.in_valid = 1'b1;
    bus.in_data0 = 64'd55;
    bus.in_data1 = 64'd66;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("done_overflow", bus.overflow, 1'b1);
    check("done_out_valid", bus.out_valid, 1'b0);
    check("done_state", dbg_state, DONE);
    check("done_count", dbg_count, 3'd0);

    // five pushes into a stalled 4-deep FIFO
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      sb_cycle(1'b1, 64'(k), 64'(100 + k), 1'b0);
      check($sformatf("stall_ovf_after_%0d", k), bus.overflow, k == 5);
    end
    check("stall_count", dbg_count, 3'd4);
    drain();

    // push and pop together while full
    do_reset();
    for (int k = 0; k < 4; k++) sb_cycle(1'b1, 64'(10 + k), 64'(20 + k), 1'b0);
    check("full_count", dbg_count, 3'd4);
    sb_cycle(1'b1, 64'd14, 64'd24, 1'b1);
    check("full_pp_count", dbg_count, 3'd4);
    check("full_pp_overflow", bus.overflow, 1'b0);
    drain();

    // random stalls and sparse input over a whole matrix
    do_reset();
    accepted = 0;
    for (int c = 0; c < 2000 && (accepted < N*N/2 || exp_q.size() > 0); c++) begin
      logic iv;
      logic rdy;
      iv  = (accepted < N*N/2) && (exp_q.size() < DEPTH) && ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 1) == 1);
      if (iv) accepted++;
      sb_cycle(iv, {$urandom, $urandom}, {$urandom, $urandom}, rdy);
    end
    check("rand_accepted", accepted, N*N/2);
    check("rand_empty", exp_q.size(), 0);
    check("rand_mat_done", bus.mat_done, 1'b1);
    check("rand_overflow", bus.overflow, 1'b0);

    // reset in the middle of a matrix, then replay it
    do_reset();
    for (int k = 0; k < 4; k++) sb_cycle(1'b1, 64'(30 + k), 64'(40 + k), 1'b0);
    for (int k = 0; k < 3; k++) sb_cycle(1'b0, 64'd0, 64'd0, 1'b1);
    check("mid_row_before", bus.out_row, 2'd1);
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data0  = 64'd99;
    bus.in_data1  = 64'd98;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    m_pos  = 0;
    m_ovf  = 1'b0;
    m_done = 1'b0;
    check_cleared("midrst");
    run_table();

`ifdef RESULT_ROWSUM_EN
    // row 0 elements 1,2,3,4
    do_reset();
    sb_cycle(1'b1, 64'd1, 64'd2, 1'b0);
    sb_cycle(1'b1, 64'd3, 64'd4, 1'b0);
    sb_cycle(1'b0, 64'd0, 64'd0, 1'b1);
    sb_cycle(1'b0, 64'd0, 64'd0, 1'b1);
    check("rowsum_row_done", bus.row_done, 1'b1);
    check("rowsum_value", bus.row_sum[63:0], 64'd10);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
